// File: rtl/fp128Pkg.sv
// Quad-precision field layout and constants shared by the integer/float convert path.
package fp128Pkg;

    localparam int FPWID = 128;
    localparam int MSB   = FPWID - 1;
    localparam int EMSB  = 14;
    localparam int FMSB  = 111;

    localparam logic [EMSB:0] BIAS = 15'h3FFF;

    typedef struct packed {
        logic            sgn;
        logic [EMSB:0]   exp;
        logic [FMSB:0]   frac;
    } fp128_t;

endpackage

// File: rtl/cntlz128.sv
// Combinational 128-bit leading-zero counter; returns 128 for an all-zero input.
module cntlz128 (
    input  logic [127:0] a,
    output logic [7:0]   cnt
);

    logic [15:0]       byte_nz;
    logic [15:0][2:0]  byte_lz;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_byte
            logic [7:0] b;
            logic [2:0] lz_loc;

            assign b = a[gi*8 +: 8];
            assign byte_nz[gi] = |b;

            // Highest set bit wins because later iterations overwrite earlier ones.
            always_comb begin
                lz_loc = 3'd0;
                for (int k = 0; k < 8; k++) begin
                    if (b[k]) lz_loc = 3'(7 - k);
                end
            end

            assign byte_lz[gi] = lz_loc;
        end
    endgenerate

    // Byte k contributes 8*(15-k) leading zeros from the bytes above it.
    always_comb begin
        cnt = 8'd128;
        for (int k = 0; k < 16; k++) begin
            if (byte_nz[k]) cnt = {1'b0, 4'(15 - k), byte_lz[k]};
        end
    end

endmodule

// File: rtl/i2f128_pipe.sv
// Three-stage 128-bit integer to quad float converter (RNE) with valid/ready flow control.
// Define I2F128_FLAGS_EN to add the registered inexact output.
module i2f128_pipe
    import fp128Pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [FPWID-1:0] i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [FPWID-1:0] o
`ifdef I2F128_FLAGS_EN
    ,
    output logic             inexact
`endif
);

    // Bit index of the guard bit once the 113 kept bits sit at the top of nm.
    localparam int GRD = MSB - FMSB - 2;

    logic             s1_valid_reg;
    logic             s1_sgn_reg;
    logic [MSB:0]     s1_mag_reg;
    logic             s1_sgn_next;
    logic [MSB:0]     s1_mag_next;

    logic             s2_valid_reg;
    logic             s2_sgn_reg;
    logic [EMSB:0]    s2_exp_reg;
    logic [MSB:0]     s2_nm_reg;
    logic [7:0]       lz;
    logic [EMSB:0]    s2_exp_next;
    logic [MSB:0]     s2_nm_next;

    logic             out_valid_reg;
    fp128_t           o_reg;
    fp128_t           res_next;
    logic             guard;
    logic             sticky;
    logic             round_up;
    logic             carry;

    logic             s3_adv;
    logic             s3_en;
    logic             s2_adv;
    logic             s2_en;
    logic             s1_adv;

    // Handshake chain: each stage frees up when it is empty or its content moves on.
    assign s3_adv   = out_valid_reg & out_ready;
    assign s3_en    = ~out_valid_reg | s3_adv;
    assign s2_adv   = s2_valid_reg & s3_en;
    assign s2_en    = ~s2_valid_reg | s2_adv;
    assign s1_adv   = s1_valid_reg & s2_en;
    assign in_ready = ~s1_valid_reg | s1_adv;

    assign out_valid = out_valid_reg;
    assign o         = o_reg;

    // S1: sign/magnitude split; -2^127 negates to itself, which is the correct magnitude.
    always_comb begin
        s1_sgn_next = op & i[MSB];
        s1_mag_next = s1_sgn_next ? -i : i;
    end

    // S2: normalise so the leading one lands on bit 127.
    cntlz128 u_clz (
        .a   (s1_mag_reg),
        .cnt (lz)
    );

    always_comb begin
        s2_nm_next  = s1_mag_reg << lz;
        s2_exp_next = BIAS + 15'd127 - {7'd0, lz};
    end

    // S3: round to nearest even; a set bit 127 doubles as the nonzero indicator.
    always_comb begin
        guard    = s2_nm_reg[GRD];
        sticky   = |s2_nm_reg[GRD-1:0];
        round_up = guard & (sticky | s2_nm_reg[GRD+1]);
        carry    = round_up & (&s2_nm_reg[MSB-1:GRD+1]);
        res_next = '0;
        if (s2_nm_reg[MSB]) begin
            res_next.sgn  = s2_sgn_reg;
            res_next.exp  = s2_exp_reg + {{EMSB{1'b0}}, carry};
            res_next.frac = s2_nm_reg[MSB-1:GRD+1] + {{FMSB{1'b0}}, round_up};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg  <= 1'b0;
            s2_valid_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            o_reg         <= '0;
        end else if (ce) begin
            if (in_ready) s1_valid_reg <= in_valid;
            if (s2_en)    s2_valid_reg <= s1_valid_reg;
            if (s3_en)    out_valid_reg <= s2_valid_reg;
            if (s3_en && s2_valid_reg) o_reg <= res_next;
        end
    end

    // Datapath registers need no reset; their valid bits qualify them.
    always_ff @(posedge clk) begin
        if (ce) begin
            if (in_ready && in_valid) begin
                s1_sgn_reg <= s1_sgn_next;
                s1_mag_reg <= s1_mag_next;
            end
            if (s2_en && s1_valid_reg) begin
                s2_sgn_reg <= s1_sgn_reg;
                s2_exp_reg <= s2_exp_next;
                s2_nm_reg  <= s2_nm_next;
            end
        end
    end

`ifdef I2F128_FLAGS_EN
    logic inexact_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            inexact_reg <= 1'b0;
        end else if (ce && s3_en && s2_valid_reg) begin
            inexact_reg <= guard | sticky;
        end
    end

    assign inexact = inexact_reg;
`endif

endmodule

// File: tb/tb_i2f128_pipe.sv
// Bench for i2f128_pipe: scoreboard against an arithmetic reference model, random traffic,
// backpressure, clock-enable freeze and mid-stream reset.
`timescale 1ns/1ps
module tb_i2f128_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b1;
    logic         ce = 1'b1;
    logic         in_valid = 1'b0;
    logic         op = 1'b0;
    logic         out_ready = 1'b1;
    logic [127:0] i = '0;
    logic         in_ready;
    logic         out_valid;
    logic [127:0] o;
`ifdef I2F128_FLAGS_EN
    logic         inexact;
`endif

    i2f128_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .i         (i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .o         (o)
`ifdef I2F128_FLAGS_EN
        ,
        .inexact   (inexact)
`endif
    );

    typedef struct packed {
        logic         inx;
        logic [127:0] val;
    } exp_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_acc = 0;
    int   n_out = 0;
    bit   rand_rdy = 1'b0;
    exp_t sb[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Reference: locate the leading one, then round the discarded remainder against one half ulp.
    function automatic exp_t model(input logic sop, input logic [127:0] x);
        exp_t         r;
        logic         neg;
        logic [127:0] mag;
        logic [127:0] q;
        logic [127:0] rem;
        logic [127:0] half;
        int           p;
        int           e;
        r   = '0;
        neg = sop & x[127];
        mag = neg ? (128'd0 - x) : x;
        if (mag == 128'd0) return r;
        p = 127;
        while (mag[p] == 1'b0) p--;
        rem = '0;
        if (p <= 112) begin
            q = mag << (112 - p);
        end else begin
            q    = mag >> (p - 112);
            rem  = mag & ((128'd1 << (p - 112)) - 128'd1);
            half = 128'd1 << (p - 113);
            if (rem > half || (rem == half && q[0])) q = q + 128'd1;
        end
        e = 16383 + p;
        if (q[113]) begin
            e = e + 1;
            q = q >> 1;
        end
        r.val = {neg, 15'(e), q[111:0]};
        r.inx = (rem != 128'd0);
        return r;
    endfunction

    function automatic logic [127:0] rnd_val();
        logic [127:0] v;
        int           p;
        v = {$urandom, $urandom, $urandom, $urandom};
        case ($urandom_range(0, 7))
            0: v = '0;
            1, 2: v = v >> $urandom_range(0, 127);
            3: v = {128{1'b1}} >> $urandom_range(0, 127);
            4: begin
                p = $urandom_range(113, 127);
                v = (128'd1 << p) | (128'd1 << (p - 113));
                if ($urandom_range(0, 1) == 1) v = v | (128'd1 << (p - 112));
            end
            default: ;
        endcase
        return v;
    endfunction

    // Scoreboard and stall-stability monitor, sampled mid-cycle.
    logic         prev_hold = 1'b0;
    logic [127:0] prev_o = '0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb.delete();
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", 128'(out_valid), 128'd1);
                check("hold_o", o, prev_o);
            end
            if (out_valid && out_ready && ce) begin
                if (sb.size() == 0) begin
                    check("unexpected_out", 128'(out_valid), 128'd0);
                end else begin
                    e = sb.pop_front();
                    check("result", o, e.val);
`ifdef I2F128_FLAGS_EN
                    check("inexact", 128'(inexact), 128'(e.inx));
`endif
                    $display("out %0d: o=%h expected=%h", n_out, o, e.val);
                    n_out++;
                end
            end
            if (in_valid && in_ready && ce) sb.push_back(model(op, i));
            prev_hold = out_valid && !(out_ready && ce);
            prev_o    = o;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one operand and hold it until a transfer edge; returns 1ns after that edge.
    task automatic push(input logic sop, input logic [127:0] x);
        bit acc;
        int wait_cnt = 0;
        in_valid = 1'b1;
        op       = sop;
        i        = x;
        forever begin
            #1;
            acc = in_ready && ce;
            @(posedge clk);
            #1;
            if (acc) break;
            wait_cnt++;
            if (wait_cnt > 500) begin
                n_cmp++;
                n_bad++;
                $display("FAIL push_timeout: got no accept want accept");
                break;
            end
        end
        in_valid = 1'b0;
        n_acc++;
    endtask

    task automatic directed(input string name, input logic sop, input logic [127:0] x,
                            input logic [127:0] want, input logic want_inx);
        exp_t m;
        m = model(sop, x);
        check({name, "_model"}, m.val, want);
        check({name, "_model_inx"}, 128'(m.inx), 128'(want_inx));
        push(sop, x);
        check({name, "_lat1"}, 128'(out_valid), 128'd0);
        step();
        check({name, "_lat2"}, 128'(out_valid), 128'd0);
        step();
        check({name, "_lat3"}, 128'(out_valid), 128'd1);
        check({name, "_o"}, o, want);
`ifdef I2F128_FLAGS_EN
        check({name, "_inexact"}, 128'(inexact), 128'(want_inx));
`endif
        step();
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sb.size() != 0 || out_valid) && n < 3000) begin
            step();
            n++;
        end
        if (n >= 3000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_o", o, 128'd0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", 128'(in_ready), 128'd1);
        step();

        directed("one", 1'b0, 128'd1, {16'h3FFF, 112'h0}, 1'b0);
        directed("neg_one", 1'b1, {128{1'b1}}, {16'hBFFF, 112'h0}, 1'b0);
        directed("all_ones", 1'b0, {128{1'b1}}, {16'h407F, 112'h0}, 1'b1);
        directed("min_neg", 1'b1, {1'b1, 127'h0}, {16'hC07E, 112'h0}, 1'b0);
        directed("zero_s", 1'b1, 128'd0, 128'd0, 1'b0);
        directed("zero_u", 1'b0, 128'd0, 128'd0, 1'b0);
        directed("tie_even", 1'b0, (128'd1 << 113) + 128'd1, {16'h4070, 112'h0}, 1'b1);
        directed("tie_up", 1'b0, (128'd1 << 113) + 128'd3, {16'h4070, 112'h2}, 1'b1);

        // Backpressure: three ops fill the pipe while the consumer stalls.
        out_ready = 1'b0;
        n_acc = 0;
        fork
            for (int k = 0; k < 8; k++) push(1'($urandom_range(0, 1)), rnd_val());
            begin
                repeat (5) @(posedge clk);
                #2;
                check("bp_in_ready", 128'(in_ready), 128'd0);
                check("bp_accepted", 128'(n_acc), 128'd3);
                rand_rdy = 1'b1;
            end
        join
        wait_drain();

        // Random traffic with a clock-enable freeze in the middle.
        fork
            for (int k = 0; k < 200; k++) begin
                if ($urandom_range(0, 3) == 0) step();
                push(1'($urandom_range(0, 1)), rnd_val());
            end
            begin
                logic [127:0] fo;
                logic         fv;
                repeat (60) @(posedge clk);
                #1;
                ce = 1'b0;
                fo = o;
                fv = out_valid;
                for (int c = 0; c < 4; c++) begin
                    @(posedge clk);
                    #1;
                    check("ce_o", o, fo);
                    check("ce_valid", 128'(out_valid), 128'(fv));
                end
                ce = 1'b1;
            end
        join
        wait_drain();

        // Reset with three ops in flight: none may surface afterwards.
        rand_rdy  = 1'b0;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) push(1'b0, rnd_val() | 128'd1);
        rst = 1'b1;
        step();
        check("mid_rst_valid", 128'(out_valid), 128'd0);
        check("mid_rst_o", o, 128'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step();
            check("no_stale", 128'(out_valid), 128'd0);
        end
        directed("post_rst", 1'b1, 128'd1 << 64, {16'h403F, 112'h0}, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
